rr_arb8_ctrl: RTL and testbench
===============================

Name: rr_arb8_ctrl

Overview:
- Round-robin arbiter/scheduler for the shared 8-way select resource (3-bit index decoded to 8 one-hot enables).
- Up to 8 requesters compete; the block grants one at a time and drives the registered 3-bit index plus a valid-gated one-hot select.
- Enforces a maximum hold time and a one-cycle turnaround gap between owners.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 for this revision.
- IDX_W, 3, width of the grant index, equal to log2(N_REQ).
- MAX_HOLD, 16, maximum consecutive grant cycles per owner; legal range is 2 or more.

Ports:
- clk  in  1  Rising-edge clock; the only clock.
- reset  in  1  Synchronous, active-high reset.
- en  in  1  When high, new grants may be issued. Does not cut an active grant.
- req  in  8  Request vector. A requester holds its bit high for the whole ownership period.
- gnt_valid  out  1  A grant is active (registered).
- gnt_idx  out  3  Index of the current owner (registered). Holds its last value when gnt_valid=0.
- gnt_onehot  out  8  Decode of gnt_idx; all zero when gnt_valid=0.
- timeout  out  1  One-cycle pulse when a grant is revoked by the MAX_HOLD limit.

Behaviour:
- Reset (sampled on the clk edge):
  - state=IDLE, gnt_valid=0, gnt_idx=0, gnt_onehot=0, timeout=0, hold_cnt=0.
  - Priority pointer ptr=7, so index 0 has first priority.
- States: IDLE, GRANT, GAP.
- Winner function (combinational):
  - Returns the first set bit of req, searching ptr+1, ptr+2, … modulo 8 (wraps 7→0).
  - ptr itself is searched last.
- IDLE:
  - If en=1 and req!=0 at edge E: gnt_idx<=winner, gnt_valid<=1, hold_cnt<=0, go to GRANT.
  - gnt_valid is visible in the cycle after edge E, so request-to-grant latency is 1 cycle.
  - Otherwise stay in IDLE.
- GRANT:
  - Each edge, hold_cnt increments.
  - Release: req[gnt_idx]=0 at an edge gives gnt_valid<=0, ptr<=gnt_idx, go to GAP.
  - Timeout: req[gnt_idx]=1 and hold_cnt=MAX_HOLD-1 gives gnt_valid<=0, timeout<=1 for one cycle, ptr<=gnt_idx, go to GAP.
  - Both conditions at once: treated as a release; no timeout pulse.
  - A grant therefore lasts at most MAX_HOLD cycles.
  - en and requests from other indices are ignored while in GRANT.
- GAP:
  - Exactly one dead cycle (gnt_valid=0) for bus turnaround.
  - At the GAP edge, the same decision as IDLE: grant if en=1 and req!=0, otherwise go to IDLE.
  - Back-to-back owners are separated by exactly 1 invalid cycle.
- ptr updates only when a grant ends, so the last owner (including a timed-out one) drops to lowest priority.
- hold_cnt width is $clog2(MAX_HOLD); it never wraps because the grant ends at MAX_HOLD-1.
- Reset mid-GRANT: the next edge forces all reset values. No timeout pulse, no GAP cycle.
- No X or Z is ever driven on outputs. gnt_onehot is strictly 0 or exactly one bit set.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, GRANT, GAP);
  - N_REQ and IDX_W constants;
  - the reset pointer constant (7).
- One natural sub-module, rr_grant_dec: 3-bit index plus valid in, 8-bit one-hot out, zero when valid=0. Instantiated for gnt_onehot.
- The winner/rotate search stays in the top module as a function.

Test Plan:
- Reset: assert reset for 2 cycles with req=8'hFF → gnt_valid=0, gnt_onehot=8'h00, timeout=0. The first grant after release is idx 0.
- Single owner: req=8'h20 at edge 2 → edge 3 gives gnt_idx=5, gnt_onehot=8'h20. Drop req[5] at edge 6 → gnt_valid=0 from edge 6; state goes GAP, then IDLE.
- Rotation with wrap: after idx 6 releases (ptr=6), req=8'b0100_0101 held; each owner drops its bit after 2 cycles → grant order 0, 2, 6, each separated by 1 dead cycle.
- Timeout: req=8'hFF held, MAX_HOLD=16 → grants 0,1,…,7,0. Each lasts 16 cycles with a timeout pulse at its end; period is 17 cycles.
- Enable gating: en=0 with req=8'h08 → no grant for 10 cycles. en=1 at edge E → gnt_idx=3 after E. Drop en during the grant → grant is held until req[3] drops.
- Reset mid-grant: owner idx 4 with hold_cnt=5; assert reset → next edge gives gnt_valid=0 and timeout=0. Release reset with req=8'h81 → gnt_idx=0.

Source files
------------

// File: rtl/rr_arb8_ctrl_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// Imported by the arbiter top and the grant decoder.
package rr_arb8_ctrl_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  // Reset pointer of 7 makes index 0 the first one searched.
  localparam logic [IDX_W-1:0] PTR_RST = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb8_ctrl_grant_dec.sv
// Index-to-one-hot decoder for the shared select resource.
// Output is all zero whenever the grant is not valid.
module rr_grant_dec
  import rr_arb8_ctrl_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  input  logic             valid_i,
  output logic [N_REQ-1:0] onehot_o
);

  // Decode the index, gated by valid.
  always_comb begin
    onehot_o = '0;
    if (valid_i) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arb8_ctrl.sv
// Round-robin arbiter for an 8-way select with hold limit
// and a single dead cycle between consecutive owners.
module rr_arb8_ctrl
  import rr_arb8_ctrl_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic             timeout
);

  localparam int HOLD_W = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'(MAX_HOLD - 1);

  state_e            state_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  idx_q;
  logic              valid_q;
  logic              timeout_q;
  logic [HOLD_W-1:0] hold_q;

  logic [IDX_W-1:0]  win_d;
  logic              start_d;

  // First set request after p, wrapping; p itself is
  // searched last. Iterating from far to near lets the
  // nearest hit overwrite the others.
  function automatic logic [IDX_W-1:0] rr_winner(
    input logic [N_REQ-1:0] r,
    input logic [IDX_W-1:0] p
  );
    logic [IDX_W-1:0] w;
    logic [IDX_W-1:0] c;
    w = p;
    for (int k = N_REQ; k >= 1; k--) begin
      c = p + IDX_W'(k);
      if (r[c]) begin
        w = c;
      end
    end
    return w;
  endfunction

  assign win_d   = rr_winner(req, ptr_q);
  assign start_d = en & (|req);

  // Grant FSM: pick, hold until release or limit, then gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= PTR_RST;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_GAP: begin
          if (start_d) begin
            state_q <= ST_GRANT;
            idx_q   <= win_d;
            valid_q <= 1'b1;
            hold_q  <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (!req[idx_q]) begin
            valid_q <= 1'b0;
            ptr_q   <= idx_q;
            state_q <= ST_GAP;
          end else if (hold_q == HOLD_LAST) begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b1;
            ptr_q     <= idx_q;
            state_q   <= ST_GAP;
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  rr_grant_dec u_dec (
    .idx_i    (idx_q),
    .valid_i  (valid_q),
    .onehot_o (gnt_onehot)
  );

  assign gnt_valid = valid_q;
  assign gnt_idx   = idx_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Bench for rr_arb8_ctrl: directed scenarios with literal
// checks plus randomized traffic against a reference model.
module tb_rr_arb8_ctrl;

  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] req;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [7:0] gnt_onehot;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  rr_arb8_ctrl #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .req        (req),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: owner, cycles owned so far, priority
  int   m_idx;
  int   m_ptr;
  int   m_held;
  logic m_valid;
  logic m_to;
  logic m_live = 1'b0;

  function automatic int pick(logic [7:0] r, int p);
    for (int k = 1; k <= 8; k++) begin
      int c;
      c = (p + k) % 8;
      if (r[c]) return c;
    end
    return p;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_idx   <= 0;
      m_to    <= 1'b0;
      m_ptr   <= 7;
      m_held  <= 0;
      m_live  <= 1'b1;
    end else if (m_valid) begin
      m_to <= 1'b0;
      if (!req[m_idx]) begin
        m_valid <= 1'b0;
        m_ptr   <= m_idx;
      end else if (m_held == MAX_HOLD) begin
        m_valid <= 1'b0;
        m_ptr   <= m_idx;
        m_to    <= 1'b1;
      end else begin
        m_held <= m_held + 1;
      end
    end else begin
      m_to <= 1'b0;
      if (en && req != 8'h00) begin
        m_valid <= 1'b1;
        m_idx   <= pick(req, m_ptr);
        m_held  <= 1;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_live) begin
      logic [7:0] exp_oh;
      exp_oh = m_valid ? (8'd1 << m_idx) : 8'd0;
      n_cmp++;
      if (gnt_valid !== m_valid || gnt_idx !== 3'(m_idx) ||
          gnt_onehot !== exp_oh || timeout !== m_to) begin
        n_bad++;
        $display("FAIL model t=%0t got v=%b i=%0d oh=%h to=%b want v=%b i=%0d oh=%h to=%b",
                 $time, gnt_valid, gnt_idx, gnt_onehot, timeout,
                 m_valid, m_idx, exp_oh, m_to);
      end
    end
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int cnt;
    int first;
    int seen;
    int exp_order [3];
    exp_order = '{0, 2, 6};

    // Reset with all requests high
    reset = 1'b1;
    en    = 1'b1;
    req   = 8'hFF;
    step(2);
    chk("rst_valid", int'(gnt_valid), 0);
    chk("rst_onehot", int'(gnt_onehot), 0);
    chk("rst_timeout", int'(timeout), 0);
    reset = 1'b0;
    step(1);
    chk("first_valid", int'(gnt_valid), 1);
    chk("first_idx", int'(gnt_idx), 0);
    req = 8'h00;
    step(1);
    chk("first_rel", int'(gnt_valid), 0);
    step(3);

    // Single owner
    req = 8'h20;
    step(1);
    chk("single_idx", int'(gnt_idx), 5);
    chk("single_oh", int'(gnt_onehot), 8'h20);
    step(2);
    req = 8'h00;
    step(1);
    chk("single_rel", int'(gnt_valid), 0);
    step(2);

    // Rotation with wrap, starting from ptr=6
    req = 8'h40;
    step(1);
    chk("rot_pre", int'(gnt_idx), 6);
    req = 8'h00;
    step(2);
    req = 8'b0100_0101;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rot_idx", int'(gnt_idx), exp_order[i]);
      chk("rot_valid", int'(gnt_valid), 1);
      step(1);
      chk("rot_hold", int'(gnt_idx), exp_order[i]);
      req[exp_order[i]] = 1'b0;
      step(1);
      chk("rot_gap", int'(gnt_valid), 0);
    end
    step(2);

    // Timeout sweep starting from ptr=7
    req = 8'h80;
    step(1);
    chk("to_pre", int'(gnt_idx), 7);
    req = 8'h00;
    step(2);
    req = 8'hFF;
    step(1);
    for (int k = 0; k < 9; k++) begin
      cnt   = 0;
      first = int'(gnt_idx);
      while (gnt_valid && cnt < 40) begin
        cnt++;
        step(1);
      end
      chk("to_len", cnt, MAX_HOLD);
      chk("to_idx", first, k % 8);
      chk("to_pulse", int'(timeout), 1);
      if (k == 8) req = 8'h00;
      step(1);
      if (k < 8) chk("to_period", int'(gnt_valid), 1);
      else chk("to_pulse_end", int'(timeout), 0);
    end
    step(2);

    // Enable gating, ptr=0
    en  = 1'b0;
    req = 8'h08;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (gnt_valid) seen++;
    end
    chk("en_block", seen, 0);
    en = 1'b1;
    step(1);
    chk("en_idx", int'(gnt_idx), 3);
    chk("en_valid", int'(gnt_valid), 1);
    en = 1'b0;
    step(3);
    chk("en_hold", int'(gnt_valid), 1);
    req = 8'h00;
    step(1);
    chk("en_rel", int'(gnt_valid), 0);
    en = 1'b1;
    step(2);

    // Reset during a grant, ptr=3
    req = 8'h10;
    step(1);
    chk("mid_idx", int'(gnt_idx), 4);
    step(5);
    reset = 1'b1;
    step(1);
    chk("mid_valid", int'(gnt_valid), 0);
    chk("mid_to", int'(timeout), 0);
    chk("mid_ridx", int'(gnt_idx), 0);
    reset = 1'b0;
    req   = 8'h81;
    step(1);
    chk("mid_after", int'(gnt_idx), 0);
    chk("mid_av", int'(gnt_valid), 1);
    req = 8'h00;
    step(2);

    // Random traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      end
      en    = ($urandom_range(0, 9) != 0);
      reset = ($urandom_range(0, 199) == 0);
      step(1);
    end
    reset = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
